// File: rtl/hazard_forwarding_unit_pkg.sv
// Shared constants for the hazard/forwarding controller.
//   - EX operand-mux select encodings, driven per source on fwd_sel.
//   - Memory-wait FSM state encodings.
package hazard_forwarding_unit_pkg;

    // EX operand-mux select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
    localparam logic [1:0] FWD_MEM = 2'b01;  // result held in EX/MEM
    localparam logic [1:0] FWD_WB  = 2'b10;  // result held in MEM/WB

    // Memory-wait FSM states
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

endpackage

// File: rtl/hazard_forwarding_unit_fwd_src_match.sv
// fwd_src_match: compares one ID-stage source operand against the EX and MEM
// producers. It produces the select this source needs once the instruction
// reaches EX, and flags a load-use hit when the EX producer is a load.
// Ports:
//   rs, rs_used                    - ID source address and its "actually read" flag
//   ex_rd, ex_reg_write, ex_mem_read - EX-stage producer
//   mem_rd, mem_reg_write          - MEM-stage producer
//   next_sel                       - select to register for the next cycle
//   load_use                       - this source depends on a load now in EX
module fwd_src_match
    import hazard_forwarding_unit_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rs,
    input  logic              rs_used,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_reg_write,
    output logic [1:0]        next_sel,
    output logic              load_use
);

    logic ex_match_s;
    logic mem_match_s;

    // Producer matching; register 0 is hardwired and never forwarded
    always_comb begin
        ex_match_s  = ex_reg_write  & rs_used & (ex_rd  != {ADDR_W{1'b0}}) & (rs == ex_rd);
        mem_match_s = mem_reg_write & rs_used & (mem_rd != {ADDR_W{1'b0}}) & (rs == mem_rd);
    end

    // Select choice: the EX producer is younger, so it wins over MEM.
    // EX moves to MEM next cycle, MEM moves to WB next cycle.
    always_comb begin
        if (ex_match_s) begin
            next_sel = FWD_MEM;
        end else if (mem_match_s) begin
            next_sel = FWD_WB;
        end else begin
            next_sel = FWD_RF;
        end
        load_use = ex_match_s & ex_mem_read;
    end

endmodule

// File: rtl/hazard_forwarding_unit.sv
// hazard_forwarding_unit: hazard detection plus registered forwarding control
// for a 5-stage pipeline, placed beside the ID/EX register.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   id_rs, id_rs_used              - ID source addresses (src i at [i*ADDR_W +: ADDR_W]) and use flags
//   ex_rd, ex_reg_write, ex_mem_read - EX-stage instruction info
//   mem_rd, mem_reg_write, mem_mem_read, mem_ready - MEM-stage instruction info, load data return
//   fwd_sel                        - registered EX mux select per source (2 bits each)
//   stall_if_id, flush_id_ex       - load-use stall and bubble (combinational)
//   freeze                         - whole-pipeline hold while a load waits on memory (combinational)
//   mem_err                        - sticky, a load wait exceeded MEM_TIMEOUT cycles
//   stall_cycles                   - saturating count of cycles with stall_if_id | freeze
module hazard_forwarding_unit
    import hazard_forwarding_unit_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int NUM_SRC     = 2,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [ADDR_W-1:0]         ex_rd,
    input  logic                      ex_reg_write,
    input  logic                      ex_mem_read,
    input  logic [ADDR_W-1:0]         mem_rd,
    input  logic                      mem_reg_write,
    input  logic                      mem_mem_read,
    input  logic                      mem_ready,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall_if_id,
    output logic                      flush_id_ex,
    output logic                      freeze,
    output logic                      mem_err,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    logic [NUM_SRC*2-1:0] next_sel_s;
    logic [NUM_SRC-1:0]   load_use_vec_s;
    logic                 load_use_s;
    logic                 freeze_cond_s;
    logic                 stall_evt_s;

    logic [NUM_SRC*2-1:0] fwd_sel_r;
    logic [0:0]           state_r;
    logic [WAIT_W-1:0]    wait_cnt_r;
    logic                 mem_err_r;
    logic [CNT_W-1:0]     stall_cnt_r;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            fwd_src_match #(
                .ADDR_W (ADDR_W)
            ) u_match (
                .rs            (id_rs[g*ADDR_W +: ADDR_W]),
                .rs_used       (id_rs_used[g]),
                .ex_rd         (ex_rd),
                .ex_reg_write  (ex_reg_write),
                .ex_mem_read   (ex_mem_read),
                .mem_rd        (mem_rd),
                .mem_reg_write (mem_reg_write),
                .next_sel      (next_sel_s[g*2 +: 2]),
                .load_use      (load_use_vec_s[g])
            );
        end
    endgenerate

    // Hazard decisions; freeze masks load-use so the load-use check is redone after the wait
    always_comb begin
        load_use_s    = |load_use_vec_s;
        freeze_cond_s = mem_mem_read & ~mem_ready;
        stall_evt_s   = freeze_cond_s | load_use_s;
        if (rst) begin
            freeze      = 1'b0;
            stall_if_id = 1'b0;
            flush_id_ex = 1'b0;
        end else begin
            freeze      = freeze_cond_s;
            stall_if_id = load_use_s & ~freeze_cond_s;
            flush_id_ex = load_use_s & ~freeze_cond_s;
        end
    end

    // Forwarding select register: hold during freeze, bubble (all RF) on load-use
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_sel_r <= {(NUM_SRC*2){1'b0}};
        end else if (freeze_cond_s) begin
            fwd_sel_r <= fwd_sel_r;
        end else if (load_use_s) begin
            fwd_sel_r <= {NUM_SRC{FWD_RF}};
        end else begin
            fwd_sel_r <= next_sel_s;
        end
    end

    // Memory-wait FSM, wait counter and sticky timeout flag.
    // The entry cycle clears the counter; each later wait cycle adds one, so
    // mem_err rises at the end of the MEM_TIMEOUT-th MEM_WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
            mem_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (freeze_cond_s) begin
                        state_r    <= ST_MEM_WAIT;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end else begin
                        state_r    <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!freeze_cond_s) begin
                        state_r <= ST_RUN;
                    end else if (wait_cnt_r != WAIT_LIMIT) begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                        if ((wait_cnt_r + WAIT_W'(1)) == WAIT_LIMIT) begin
                            mem_err_r <= 1'b1;
                        end else begin
                            mem_err_r <= mem_err_r;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_evt_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign fwd_sel      = fwd_sel_r;
    assign mem_err      = mem_err_r;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed self-checking bench for hazard_forwarding_unit (NUM_SRC=2, MEM_TIMEOUT=4).
module tb_hazard_forwarding_unit;

    logic        clk;
    logic        rst;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_ready;
    logic [3:0]  fwd_sel;
    logic        stall_if_id;
    logic        flush_id_ex;
    logic        freeze;
    logic        mem_err;
    logic [15:0] stall_cycles;

    int checks;
    int passed;
    int exp_stalls;

    hazard_forwarding_unit #(
        .ADDR_W      (5),
        .NUM_SRC     (2),
        .CNT_W       (16),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rs_used    (id_rs_used),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .mem_ready     (mem_ready),
        .fwd_sel       (fwd_sel),
        .stall_if_id   (stall_if_id),
        .flush_id_ex   (flush_id_ex),
        .freeze        (freeze),
        .mem_err       (mem_err),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_rs         = 10'd0;
        id_rs_used    = 2'b00;
        ex_rd         = 5'd0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        mem_rd        = 5'd0;
        mem_reg_write = 1'b0;
        mem_mem_read  = 1'b0;
        mem_ready     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst          = 1'b1;
        mem_mem_read = 1'b1;
        ex_rd        = 5'd5;
        ex_reg_write = 1'b1;
        ex_mem_read  = 1'b1;
        id_rs[4:0]   = 5'd5;
        id_rs_used   = 2'b01;
        #1;
        checks++;
        if ({freeze, stall_if_id, flush_id_ex} !== 3'b000)
            $display("FAIL reset_comb: got %b want 000", {freeze, stall_if_id, flush_id_ex});
        else passed++;
        step();
        step();
        checks++;
        if ({fwd_sel, mem_err, stall_cycles} !== 21'd0)
            $display("FAIL reset_regs: fwd_sel=%b mem_err=%b stall_cycles=%0d want 0", fwd_sel, mem_err, stall_cycles);
        else passed++;
        rst = 1'b0;
        clear_inputs();
        exp_stalls = 0;
    endtask

    task automatic test_ex_fwd();
        clear_inputs();
        ex_rd        = 5'd3;
        ex_reg_write = 1'b1;
        id_rs[4:0]   = 5'd3;
        id_rs_used   = 2'b01;
        #1;
        checks++;
        if ({stall_if_id, flush_id_ex, freeze} !== 3'b000)
            $display("FAIL ex_fwd_nostall: got %b want 000", {stall_if_id, flush_id_ex, freeze});
        else passed++;
        step();
        checks++;
        if (fwd_sel !== 4'b0001) $display("FAIL ex_fwd_sel: got %b want 0001", fwd_sel);
        else passed++;
    endtask

    task automatic test_priority();
        clear_inputs();
        id_rs[9:5]    = 5'd4;
        id_rs_used    = 2'b10;
        ex_rd         = 5'd4;
        ex_reg_write  = 1'b1;
        mem_rd        = 5'd4;
        mem_reg_write = 1'b1;
        step();
        checks++;
        if (fwd_sel !== 4'b0100) $display("FAIL ex_beats_mem: got %b want 0100", fwd_sel);
        else passed++;
        clear_inputs();
        id_rs_used    = 2'b01;
        ex_reg_write  = 1'b1;
        mem_reg_write = 1'b1;
        step();
        checks++;
        if (fwd_sel !== 4'b0000) $display("FAIL reg0_nomatch: got %b want 0000", fwd_sel);
        else passed++;
        clear_inputs();
        id_rs[4:0]    = 5'd7;
        id_rs_used    = 2'b01;
        mem_rd        = 5'd7;
        mem_reg_write = 1'b1;
        step();
        checks++;
        if (fwd_sel !== 4'b0010) $display("FAIL mem_fwd_wb: got %b want 0010", fwd_sel);
        else passed++;
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_rd        = 5'd5;
        ex_reg_write = 1'b1;
        ex_mem_read  = 1'b1;
        id_rs[4:0]   = 5'd5;
        id_rs_used   = 2'b01;
        #1;
        checks++;
        if ({stall_if_id, flush_id_ex, freeze} !== 3'b110)
            $display("FAIL load_use_stall: got %b want 110", {stall_if_id, flush_id_ex, freeze});
        else passed++;
        step();
        exp_stalls++;
        checks++;
        if (fwd_sel !== 4'b0000) $display("FAIL load_use_bubble: got %b want 0000", fwd_sel);
        else passed++;
        // load advances to MEM with data already returned
        ex_rd         = 5'd0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        mem_rd        = 5'd5;
        mem_reg_write = 1'b1;
        mem_mem_read  = 1'b1;
        mem_ready     = 1'b1;
        #1;
        checks++;
        if ({stall_if_id, flush_id_ex, freeze} !== 3'b000)
            $display("FAIL load_use_release: got %b want 000", {stall_if_id, flush_id_ex, freeze});
        else passed++;
        step();
        checks++;
        if (fwd_sel !== 4'b0010) $display("FAIL load_use_wb: got %b want 0010", fwd_sel);
        else passed++;
        checks++;
        if (stall_cycles !== 16'(exp_stalls))
            $display("FAIL load_use_count: got %0d want %0d", stall_cycles, exp_stalls);
        else passed++;
    endtask

    task automatic test_load_unused();
        clear_inputs();
        ex_rd        = 5'd5;
        ex_reg_write = 1'b1;
        ex_mem_read  = 1'b1;
        id_rs[4:0]   = 5'd5;
        id_rs_used   = 2'b00;
        #1;
        checks++;
        if (stall_if_id !== 1'b0) $display("FAIL load_unused_stall: got %b want 0", stall_if_id);
        else passed++;
        step();
        checks++;
        if (fwd_sel !== 4'b0000) $display("FAIL load_unused_sel: got %b want 0000", fwd_sel);
        else passed++;
    endtask

    task automatic test_freeze();
        clear_inputs();
        ex_rd        = 5'd3;
        ex_reg_write = 1'b1;
        id_rs[4:0]   = 5'd3;
        id_rs_used   = 2'b01;
        step();
        checks++;
        if (fwd_sel !== 4'b0001) $display("FAIL freeze_pre: got %b want 0001", fwd_sel);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            mem_rd        = 5'd9;
            mem_reg_write = 1'b1;
            mem_mem_read  = 1'b1;
            mem_ready     = 1'b0;
            ex_rd         = 5'd9;
            ex_reg_write  = 1'b1;
            ex_mem_read   = 1'b1;
            id_rs[4:0]    = 5'd9;
            id_rs_used    = 2'b01;
            #1;
            checks++;
            if ({freeze, stall_if_id, flush_id_ex} !== 3'b100)
                $display("FAIL freeze_cycle%0d: got %b want 100", k, {freeze, stall_if_id, flush_id_ex});
            else passed++;
            step();
            exp_stalls++;
            checks++;
            if (fwd_sel !== 4'b0001) $display("FAIL freeze_hold%0d: got %b want 0001", k, fwd_sel);
            else passed++;
        end
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        mem_ready    = 1'b1;
        #1;
        checks++;
        if ({freeze, stall_if_id} !== 2'b00)
            $display("FAIL freeze_release: got %b want 00", {freeze, stall_if_id});
        else passed++;
        step();
        checks++;
        if (fwd_sel !== 4'b0010) $display("FAIL freeze_after_sel: got %b want 0010", fwd_sel);
        else passed++;
        checks++;
        if (stall_cycles !== 16'(exp_stalls) || mem_err !== 1'b0)
            $display("FAIL freeze_count: stall_cycles=%0d mem_err=%b want %0d and 0", stall_cycles, mem_err, exp_stalls);
        else passed++;
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        ex_rd        = 5'd3;
        ex_reg_write = 1'b1;
        id_rs[4:0]   = 5'd3;
        id_rs_used   = 2'b01;
        step();
        checks++;
        if (fwd_sel !== 4'b0001) $display("FAIL b2b_first: got %b want 0001", fwd_sel);
        else passed++;
        ex_rd         = 5'd6;
        mem_rd        = 5'd3;
        mem_reg_write = 1'b1;
        id_rs         = {5'd6, 5'd3};
        id_rs_used    = 2'b11;
        step();
        checks++;
        if (fwd_sel !== 4'b0110) $display("FAIL b2b_second: got %b want 0110", fwd_sel);
        else passed++;
        ex_reg_write = 1'b0;
        mem_rd       = 5'd6;
        step();
        checks++;
        if (fwd_sel !== 4'b1000) $display("FAIL b2b_third: got %b want 1000", fwd_sel);
        else passed++;
    endtask

    task automatic test_timeout();
        clear_inputs();
        step();
        for (int k = 0; k < 6; k++) begin
            mem_rd       = 5'd2;
            mem_mem_read = 1'b1;
            mem_ready    = 1'b0;
            #1;
            checks++;
            if (freeze !== 1'b1) $display("FAIL timeout_freeze%0d: got %b want 1", k, freeze);
            else passed++;
            step();
            exp_stalls++;
            checks++;
            if (mem_err !== (k >= 4)) $display("FAIL timeout_err%0d: got %b want %b", k, mem_err, (k >= 4));
            else passed++;
        end
        checks++;
        if (stall_cycles !== 16'(exp_stalls))
            $display("FAIL timeout_count: got %0d want %0d", stall_cycles, exp_stalls);
        else passed++;
        // reset in the middle of the freeze
        rst = 1'b1;
        #1;
        checks++;
        if ({freeze, stall_if_id, flush_id_ex} !== 3'b000)
            $display("FAIL rst_mid_freeze_comb: got %b want 000", {freeze, stall_if_id, flush_id_ex});
        else passed++;
        step();
        exp_stalls = 0;
        checks++;
        if ({fwd_sel, mem_err, stall_cycles} !== 21'd0)
            $display("FAIL rst_mid_freeze_regs: fwd_sel=%b mem_err=%b stall_cycles=%0d want 0", fwd_sel, mem_err, stall_cycles);
        else passed++;
        rst = 1'b0;
        // a fresh wait must start from RUN with a cleared counter
        for (int k = 0; k < 5; k++) begin
            step();
            exp_stalls++;
            checks++;
            if (mem_err !== (k >= 4)) $display("FAIL rerun_err%0d: got %b want %b", k, mem_err, (k >= 4));
            else passed++;
        end
        mem_ready = 1'b1;
        step();
        checks++;
        if (mem_err !== 1'b1 || stall_cycles !== 16'(exp_stalls))
            $display("FAIL err_sticky: mem_err=%b stall_cycles=%0d want 1 and %0d", mem_err, stall_cycles, exp_stalls);
        else passed++;
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        exp_stalls = 0;
        rst        = 1'b1;
        clear_inputs();
        test_reset();
        test_ex_fwd();
        test_priority();
        test_load_use();
        test_load_unused();
        test_freeze();
        test_back_to_back();
        test_timeout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
